sobel_window_grad: RTL and testbench

//  Downstream of the sobel line buffer. Takes three vertically aligned grey pixels per cycle:
//  - row0 = two lines up, from the second line FIFO.
//  - row1 = one line up, from the first line FIFO.
//  - row2 = current line.

---
 rtl/sobel_window_grad_if.sv | 39 +++
 rtl/sobel_window_grad.sv | 148 ++++++++++++++
 tb/tb_sobel_window_grad.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_grad_if.sv
// sobel_window_grad_if
//   Video stream bundle around the Sobel window/gradient stage.
//   master: the upstream line buffer / bench; drives the three aligned pixel rows, the syncs and
//           the per-frame threshold, and receives the delayed syncs and the edge results.
//   slave : the gradient stage itself.
//   Signals
//     in_vs, in_hs, in_de  input syncs and data enable (active high)
//     row0, row1, row2     pixels from two lines up, one line up and the current line
//     threshold            binary edge threshold (MAG_W bits), taken once per frame
//     out_vs/out_hs/out_de syncs delayed to match the pipeline
//     edge_mag, edge_bin   saturated gradient magnitude and thresholded edge flag
interface sobel_window_grad_if #(
    parameter int unsigned PIX_W = 8
) ();
    localparam int unsigned MAG_W = PIX_W + 3;

    logic             in_vs;
    logic             in_hs;
    logic             in_de;
    logic [PIX_W-1:0] row0;
    logic [PIX_W-1:0] row1;
    logic [PIX_W-1:0] row2;
    logic [MAG_W-1:0] threshold;
    logic             out_vs;
    logic             out_hs;
    logic             out_de;
    logic [PIX_W-1:0] edge_mag;
    logic             edge_bin;

    modport master (
        output in_vs, in_hs, in_de, row0, row1, row2, threshold,
        input  out_vs, out_hs, out_de, edge_mag, edge_bin
    );

    modport slave (
        input  in_vs, in_hs, in_de, row0, row1, row2, threshold,
        output out_vs, out_hs, out_de, edge_mag, edge_bin
    );
endinterface

// File: rtl/sobel_window_grad.sv
// sobel_window_grad
//   Builds a 3x3 window from three vertically aligned pixel rows, computes |Gx|+|Gy| and emits a
//   saturated grey edge value plus a thresholded binary edge, four cycles after the input sample.
//   Syncs are delayed by the same amount. Pixels whose window is not yet complete (first two
//   columns of a line, first two lines of a frame) are forced to zero when BORDER_ZERO is set.
//   Ports
//     clk  pixel clock
//     rst  synchronous, active-high reset
//     vid  sobel_window_grad_if.slave (input rows/syncs/threshold, output edge results/syncs)
module sobel_window_grad #(
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned BORDER_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst,
    sobel_window_grad_if.slave vid
);
    localparam int unsigned MAG_W = PIX_W + 3;
    localparam int unsigned SUM_W = PIX_W + 2;
    localparam int unsigned CNT_W = 12;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [MAG_W-1:0] SatMax = {3'b000, {PIX_W{1'b1}}};

    // p[r][c]: r = 0 top .. 2 bottom, c = 2 newest column
    logic [PIX_W-1:0] win_q [3][3];

    logic             vs_prev_q, de_prev_q;
    logic [CNT_W-1:0] col_cnt_q, row_cnt_q;
    logic [MAG_W-1:0] thr_q;

    // Bit i holds the value sampled i+1 cycles ago; bit 3 drives the outputs.
    logic [3:0]       vs_dly_q, hs_dly_q, de_dly_q, inc_dly_q;

    logic [SUM_W-1:0] gx_pos_q, gx_neg_q, gy_pos_q, gy_neg_q;
    logic [SUM_W-1:0] gx_abs_q, gy_abs_q;
    logic [PIX_W-1:0] edge_mag_q;
    logic             edge_bin_q;

    logic             vs_rise, de_fall, incomplete, pix_ok;
    logic [MAG_W-1:0] mag;
    logic [PIX_W-1:0] mag_sat;

    function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // |a - b| of two unsigned sums; equals |signed difference| without sign extension.
    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        vs_rise    = vid.in_vs & ~vs_prev_q;
        de_fall    = ~vid.in_de & de_prev_q;
        // Counts before this pixel's increment
        incomplete = (col_cnt_q < CNT_W'(2)) | (row_cnt_q < CNT_W'(2));
        mag        = {1'b0, gx_abs_q} + {1'b0, gy_abs_q};
        mag_sat    = (mag > SatMax) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
        pix_ok     = de_dly_q[2] & ~((BORDER_ZERO != 0) & inc_dly_q[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            thr_q      <= '0;
            vs_dly_q   <= '0;
            hs_dly_q   <= '0;
            de_dly_q   <= '0;
            inc_dly_q  <= '0;
            gx_pos_q   <= '0;
            gx_neg_q   <= '0;
            gy_pos_q   <= '0;
            gy_neg_q   <= '0;
            gx_abs_q   <= '0;
            gy_abs_q   <= '0;
            edge_mag_q <= '0;
            edge_bin_q <= 1'b0;
        end else begin
            vs_prev_q <= vid.in_vs;
            de_prev_q <= vid.in_de;

            // S1: window shift
            if (vid.in_de) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= vid.row0;
                win_q[1][2] <= vid.row1;
                win_q[2][2] <= vid.row2;
            end

            if (de_fall) begin
                col_cnt_q <= '0;
            end else if (vid.in_de && col_cnt_q != CntMax) begin
                col_cnt_q <= col_cnt_q + 1'b1;
            end

            // A frame start overrides a coincident line end.
            if (vs_rise) begin
                row_cnt_q <= '0;
            end else if (de_fall && row_cnt_q != CntMax) begin
                row_cnt_q <= row_cnt_q + 1'b1;
            end

            if (vs_rise) begin
                thr_q <= vid.threshold;
            end

            vs_dly_q  <= {vs_dly_q[2:0], vid.in_vs};
            hs_dly_q  <= {hs_dly_q[2:0], vid.in_hs};
            de_dly_q  <= {de_dly_q[2:0], vid.in_de};
            inc_dly_q <= {inc_dly_q[2:0], incomplete};

            // S2: weighted column/row sums
            gx_pos_q <= wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
            gx_neg_q <= wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
            gy_pos_q <= wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
            gy_neg_q <= wsum(win_q[0][0], win_q[0][1], win_q[0][2]);

            // S3: absolute gradients
            gx_abs_q <= abs_diff(gx_pos_q, gx_neg_q);
            gy_abs_q <= abs_diff(gy_pos_q, gy_neg_q);

            // S4: magnitude, saturation, threshold
            edge_mag_q <= pix_ok ? mag_sat : '0;
            edge_bin_q <= pix_ok & (mag > thr_q);
        end
    end

    assign vid.out_vs   = vs_dly_q[3];
    assign vid.out_hs   = hs_dly_q[3];
    assign vid.out_de   = de_dly_q[3];
    assign vid.edge_mag = edge_mag_q;
    assign vid.edge_bin = edge_bin_q;
endmodule

// File: tb/tb_sobel_window_grad.sv
// tb_sobel_window_grad
//   Drives whole frames from an image array and compares every output cycle with a reference
//   that convolves the image with the Sobel kernels directly.
module tb_sobel_window_grad;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned MAG_W = PIX_W + 3;
    localparam int          W     = 16;
    localparam int          H_MAX = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sobel_window_grad_if #(.PIX_W(PIX_W)) vid ();

    sobel_window_grad #(
        .PIX_W      (PIX_W),
        .BORDER_ZERO(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid(vid)
    );

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic [PIX_W-1:0] mag;
        logic             bin;
    } exp_t;

    exp_t exp_q[$];
    int   img [H_MAX][W];

    int n_checks = 0;
    int n_pass   = 0;
    int in_de_cnt, out_de_cnt;

    // Reference bookkeeping: position of the pixel inside the line/frame as the DUT sees it.
    logic m_vs_prev, m_de_prev;
    int   m_x, m_y, m_thr;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    endtask

    function automatic int sobel_ref(input int fx, input int fy);
        int kx[9];
        int ky[9];
        int gx, gy, p;
        kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p  = img[fy - 2 + i][fx - 2 + j];
                gx += kx[i * 3 + j] * p;
                gy += ky[i * 3 + j] * p;
            end
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    task automatic model_sample(input logic r, input logic vs, input logic hs, input logic de,
                                input int fx, input int fy, input int thr_in);
        exp_t e;
        int   m;
        logic inc;
        e = '0;
        if (r) begin
            m_vs_prev = 1'b0;
            m_de_prev = 1'b0;
            m_x       = 0;
            m_y       = 0;
            m_thr     = 0;
            // Pipeline contents are lost: the next three outputs are zero as well.
            exp_q = {};
            for (int i = 0; i < 3; i++) exp_q.push_back('0);
        end else begin
            if (vs && !m_vs_prev) m_thr = thr_in;
            inc  = (m_x < 2) || (m_y < 2);
            e.vs = vs;
            e.hs = hs;
            e.de = de;
            if (de && !inc) begin
                m     = sobel_ref(fx, fy);
                e.mag = PIX_W'((m > 255) ? 255 : m);
                e.bin = (m > m_thr);
            end
            if (de) m_x = (m_x < 4095) ? m_x + 1 : m_x;
            if (!de && m_de_prev) begin
                m_x = 0;
                m_y = (m_y < 4095) ? m_y + 1 : m_y;
            end
            if (vs && !m_vs_prev) m_y = 0;
            m_vs_prev = vs;
            m_de_prev = de;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic vs, input logic hs, input logic de,
                         input int fx, input int fy);
        exp_t e;
        rst       = r;
        vid.in_vs = vs;
        vid.in_hs = hs;
        vid.in_de = de;
        if (de) begin
            vid.row2 = PIX_W'(img[fy][fx]);
            vid.row1 = (fy >= 1) ? PIX_W'(img[fy - 1][fx]) : '0;
            vid.row0 = (fy >= 2) ? PIX_W'(img[fy - 2][fx]) : '0;
        end else begin
            vid.row0 = PIX_W'($urandom);
            vid.row1 = PIX_W'($urandom);
            vid.row2 = PIX_W'($urandom);
        end
        @(posedge clk);
        model_sample(r, vs, hs, de, fx, fy, int'(vid.threshold));
        if (!r && de) in_de_cnt++;
        #1;
        e = exp_q.pop_front();
        check_eq("out_vs", int'(vid.out_vs), int'(e.vs));
        check_eq("out_hs", int'(vid.out_hs), int'(e.hs));
        check_eq("out_de", int'(vid.out_de), int'(e.de));
        check_eq("edge_mag", int'(vid.edge_mag), int'(e.mag));
        check_eq("edge_bin", int'(vid.edge_bin), int'(e.bin));
        if (vid.out_de) out_de_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // thr_mid >= 0 changes the threshold input at line 3; rst_line >= 0 pulses reset at column 5.
    task automatic run_frame(input int w, input int h, input int thr, input int thr_mid,
                             input int rst_line);
        vid.threshold = MAG_W'(thr);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(2);
        for (int y = 0; y < h; y++) begin
            if (y == 3 && thr_mid >= 0) vid.threshold = MAG_W'(thr_mid);
            for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
            idle(2);
            for (int x = 0; x < w; x++) cycle((y == rst_line) && (x == 5), 1'b0, 1'b0, 1'b1, x, y);
            idle(3);
        end
        idle(4);
    endtask

    initial begin
        rst           = 1'b1;
        vid.in_vs     = 1'b0;
        vid.in_hs     = 1'b0;
        vid.in_de     = 1'b0;
        vid.row0      = '0;
        vid.row1      = '0;
        vid.row2      = '0;
        vid.threshold = '0;
        m_vs_prev     = 1'b0;
        m_de_prev     = 1'b0;
        m_x           = 0;
        m_y           = 0;
        m_thr         = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(3);

        // Flat field: no edges, every enabled input pixel comes out
        for (int y = 0; y < H_MAX; y++) for (int x = 0; x < W; x++) img[y][x] = 128;
        in_de_cnt  = 0;
        out_de_cnt = 0;
        run_frame(16, 8, 10, -1, -1);
        check_eq("de_count", out_de_cnt, in_de_cnt);

        // Vertical step at column 8
        for (int y = 0; y < H_MAX; y++) for (int x = 0; x < W; x++) img[y][x] = (x < 8) ? 0 : 255;
        run_frame(16, 8, 100, -1, -1);

        // Horizontal step at row 4
        for (int y = 0; y < H_MAX; y++) for (int x = 0; x < W; x++) img[y][x] = (y < 4) ? 0 : 255;
        run_frame(16, 8, 100, -1, -1);

        // Ramp of 5 per column: magnitude exactly 40; threshold 40, then 39 from line 3 onward
        for (int y = 0; y < H_MAX; y++) for (int x = 0; x < W; x++) img[y][x] = 5 * x;
        run_frame(16, 8, 40, 39, -1);
        run_frame(16, 8, 39, -1, -1);

        // Random images
        for (int f = 0; f < 3; f++) begin
            for (int y = 0; y < H_MAX; y++) for (int x = 0; x < W; x++)
                img[y][x] = int'($urandom_range(0, 255));
            run_frame(16, 10, int'($urandom_range(0, 1200)), -1, -1);
        end

        // Reset mid line 5, then a clean frame
        for (int y = 0; y < H_MAX; y++) for (int x = 0; x < W; x++)
            img[y][x] = int'($urandom_range(0, 255));
        run_frame(16, 8, 200, -1, 5);
        run_frame(16, 8, 200, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
